// File: rtl/ibex_rf_wb_arbiter.sv
// Single write-port arbiter for the register file: zero-latency pipeline
// writeback (A) shares the port with a queued long-latency unit (B).
module ibex_rf_wb_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned Depth     = 2,
  parameter int unsigned MaxWait   = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,

  input  logic                       a_valid_i,
  output logic                       a_ready_o,
  input  logic [AddrWidth-1:0]       a_waddr_i,
  input  logic [DataWidth-1:0]       a_wdata_i,

  input  logic                       b_valid_i,
  output logic                       b_ready_o,
  input  logic [AddrWidth-1:0]       b_waddr_i,
  input  logic [DataWidth-1:0]       b_wdata_i,

  output logic                       rf_we_o,
  output logic [AddrWidth-1:0]       rf_waddr_o,
  output logic [DataWidth-1:0]       rf_wdata_o,

  input  logic [AddrWidth-1:0]       raddr_a_i,
  input  logic [AddrWidth-1:0]       raddr_b_i,
  output logic                       hazard_a_o,
  output logic                       hazard_b_o,

  output logic [$clog2(Depth+1)-1:0] pending_o
);

  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam int unsigned WaitW = $clog2(MaxWait + 1);

  logic [Depth-1:0]     live_q, live_d;
  logic [AddrWidth-1:0] waddr_q [Depth];
  logic [DataWidth-1:0] wdata_q [Depth];
  logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]      count_q;
  logic [WaitW-1:0]     wait_q;

  logic full, empty, head_live, force_b;
  logic grant_a, grant_b, kill_en, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign full      = (count_q == CntW'(Depth));
  assign empty     = (count_q == '0);
  assign head_live = !empty && live_q[rd_ptr_q];
  assign force_b   = head_live && ((wait_q == WaitW'(MaxWait)) || full);

  assign a_ready_o = !force_b;
  assign b_ready_o = !full;
  assign pending_o = count_q;

  assign grant_a = a_valid_i && !force_b;
  assign grant_b = head_live && (force_b || !a_valid_i);
  assign kill_en = grant_a && (a_waddr_i != '0);
  // A killed head leaves without the port; a live head leaves only when granted.
  assign pop     = (!empty && !live_q[rd_ptr_q]) || grant_b;
  assign push    = b_valid_i && !full && (b_waddr_i != '0);

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = a_waddr_i;
    rf_wdata_o = a_wdata_i;
    if (grant_b) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = waddr_q[rd_ptr_q];
      rf_wdata_o = wdata_q[rd_ptr_q];
    end else if (grant_a) begin
      rf_we_o    = (a_waddr_i != '0);
    end
  end

  // A is younger than every B result, including one pushed this same cycle.
  always_comb begin
    live_d = live_q;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (kill_en && live_q[i] && (waddr_q[i] == a_waddr_i)) begin
        live_d[i] = 1'b0;
      end
    end
    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      live_d[wr_ptr_q] = !(kill_en && (b_waddr_i == a_waddr_i));
    end
  end

  always_comb begin
    hazard_a_o = 1'b0;
    hazard_b_o = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (live_q[i] && (raddr_a_i != '0) && (waddr_q[i] == raddr_a_i)) begin
        hazard_a_o = 1'b1;
      end
      if (live_q[i] && (raddr_b_i != '0) && (waddr_q[i] == raddr_b_i)) begin
        hazard_b_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      live_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        waddr_q[i] <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      live_q <= live_d;
      if (push) begin
        waddr_q[wr_ptr_q] <= b_waddr_i;
        wdata_q[wr_ptr_q] <= b_wdata_i;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_q <= '0;
    end else if (pop || empty) begin
      wait_q <= '0;
    end else if (head_live && !grant_b && (wait_q != WaitW'(MaxWait))) begin
      wait_q <= wait_q + 1'b1;
    end
  end

endmodule
